// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - operand/control/result bundle for the iterative multiply/divide unit
//
// Ports carried:
//   data_operandA, data_operandB : signed operands (dividend/multiplicand, divisor/multiplier)
//   ctrl_MULT, ctrl_DIV          : start strobes, sampled every rising edge
//   data_result, data_exception  : registered result and overflow/div-by-zero flag
//   data_resultRDY               : one-cycle result-valid strobe
//   busy                         : high while an operation is stepping
// Modports: master drives operands/starts, slave is the arithmetic unit.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed 32-bit shift-add multiply / restoring divide
//
// Ports:
//   clock         : sole clock, rising edge
//   ctrl_reset_n  : synchronous active-low reset
//   bus           : multdiv_if.slave (operands, start strobes, result, exception, ready, busy)
// Optional build macro: MULTDIV_EARLY_DIV0_EN - a divide by zero skips the 32 steps and
// completes in the cycle after the start edge.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     ctrl_reset_n,
    multdiv_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               op_div_q, op_div_d;
    logic               neg_q, neg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   opd_q, opd_d;       // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH:0]   p_q, p_d;           // {hi(33), lo(32)} working register
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;

    logic               start, start_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               div_qbit;
    logic [WIDTH:0]     div_rem;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH:0]   step_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic               mul_exc, div_exc;
    logic [WIDTH-1:0]   div_res;

    // Starts are ignored while stepping; MULT wins when both strobes are high.
    assign start     = (state_q != ST_RUN) && (bus.ctrl_MULT || bus.ctrl_DIV);
    assign start_div = !bus.ctrl_MULT && bus.ctrl_DIV;
    assign a_mag     = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
    assign b_mag     = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

    // Multiply step: lo holds the multiplier; add multiplicand into hi on lo[0], shift right.
    assign mul_sum  = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, opd_q} : '0);
    assign mul_next = {1'b0, mul_sum, p_q[WIDTH-1:1]};

    // Restoring divide step: remainder in hi, dividend shifts out of lo as quotient bits shift in.
    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, opd_q};
    assign div_qbit  = !div_trial[WIDTH+1];
    assign div_rem   = div_qbit ? div_trial[WIDTH:0] : div_shift;
    assign div_next  = {div_rem, p_q[WIDTH-2:0], div_qbit};

    assign step_next = op_div_q ? div_next : mul_next;

    // Final-step result formation uses the value the last step is about to produce.
    assign prod_s  = neg_q ? ('0 - step_next[2*WIDTH-1:0]) : step_next[2*WIDTH-1:0];
    assign mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    assign quot_s  = neg_q ? ('0 - step_next[WIDTH-1:0]) : step_next[WIDTH-1:0];
    // A positive quotient with the top bit set is only reachable via 0x80000000 / -1.
    assign div_exc = bzero_q || (!neg_q && step_next[WIDTH-1]);
    assign div_res = bzero_q ? '0 : quot_s;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        opd_d    = opd_q;
        p_d      = p_q;
        res_d    = res_q;
        exc_d    = exc_q;
        if (start) begin
            op_div_d = start_div;
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            bzero_d  = (bus.data_operandB == '0);
            cnt_d    = '0;
            state_d  = ST_RUN;
            if (start_div) begin
                opd_d = b_mag;
                p_d   = {{(WIDTH+1){1'b0}}, a_mag};
            end else begin
                opd_d = a_mag;
                p_d   = {{(WIDTH+1){1'b0}}, b_mag};
            end
`ifdef MULTDIV_EARLY_DIV0_EN
            if (start_div && (bus.data_operandB == '0)) begin
                state_d = ST_DONE;
                res_d   = '0;
                exc_d   = 1'b1;
            end
`endif
        end else if (state_q == ST_RUN) begin
            p_d   = step_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d = ST_DONE;
                res_d   = op_div_q ? div_res : prod_s[WIDTH-1:0];
                exc_d   = op_div_q ? div_exc : mul_exc;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            opd_q    <= '0;
            p_q      <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            opd_q    <= opd_d;
            p_q      <= p_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == ST_DONE);
    assign bus.busy           = (state_q == ST_RUN);
endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - directed table-driven bench for multdiv_iter
module tb_multdiv_iter;
    logic clock;
    logic ctrl_reset_n;
    multdiv_if mif ();

    multdiv_iter dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (mif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Latency = number of rising edges after the start edge until RDY is observed.
`ifdef MULTDIV_EARLY_DIV0_EN
    localparam int DIV0_LAT = 0;
`else
    localparam int DIV0_LAT = 32;
`endif

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[14];
    int   total;
    int   passed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive a start at the current sampling point, then watch until RDY (bounded).
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        mif.ctrl_MULT     = m;
        mif.ctrl_DIV      = d;
        mif.data_operandA = a;
        mif.data_operandB = b;
        @(posedge clock); #1;
        mif.ctrl_MULT     = 1'b0;
        mif.ctrl_DIV      = 1'b0;
        mif.data_operandA = $urandom;
        mif.data_operandB = $urandom;
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (mif.data_resultRDY) begin
                lat = k;
                break;
            end
            if (mif.busy) bcnt++;
            @(posedge clock); #1;
        end
    endtask

    int lat, bcnt, rdy_pulses;
    logic [31:0] held;

    initial begin
        total = 0;
        passed = 0;
        vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32};
        vecs[1]  = '{1'b1, 1'b0, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1, 32};
        vecs[2]  = '{1'b1, 1'b0, 32'd46341,      32'd46341,    32'h80001219, 1'b1, 32};
        vecs[3]  = '{1'b1, 1'b0, 32'h80000000,   32'd1,        32'h80000000, 1'b0, 32};
        vecs[4]  = '{1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1, 32};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 1'b0, 32};
        vecs[6]  = '{1'b1, 1'b1, 32'd6,          32'd3,        32'h00000012, 1'b0, 32};
        vecs[7]  = '{1'b0, 1'b1, 32'd100,        32'd7,        32'h0000000E, 1'b0, 32};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'h0000000E, 1'b0, 32};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,          32'hFFFFFF9C, 32'h00000000, 1'b0, 32};
        vecs[10] = '{1'b0, 1'b1, 32'h80000000,   32'd1,        32'h80000000, 1'b0, 32};
        vecs[11] = '{1'b0, 1'b1, 32'd100,        32'd0,        32'h00000000, 1'b1, DIV0_LAT};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFB,   32'd0,        32'h00000000, 1'b1, DIV0_LAT};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0, 32};

        ctrl_reset_n      = 1'b0;
        mif.ctrl_MULT     = 1'b0;
        mif.ctrl_DIV      = 1'b0;
        mif.data_operandA = '0;
        mif.data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", 64'(mif.data_result), 64'd0);
        check("reset exc",    64'(mif.data_exception), 64'd0);
        check("reset rdy",    64'(mif.data_resultRDY), 64'd0);
        check("reset busy",   64'(mif.busy), 64'd0);
        ctrl_reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("v%0d result", i), 64'(mif.data_result), 64'(vecs[i].res));
            check($sformatf("v%0d exc", i),    64'(mif.data_exception), 64'(vecs[i].exc));
            check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d busy cycles", i), 64'(bcnt), 64'((vecs[i].lat == 32) ? 32 : 0));
            held = mif.data_result;
            @(posedge clock); #1;
            check($sformatf("v%0d rdy one cycle", i), 64'(mif.data_resultRDY), 64'd0);
            check($sformatf("v%0d result held", i), 64'(mif.data_result), 64'(held));
        end

        // Back-to-back: second DIV started in the RDY cycle of the first.
        do_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        check("b2b first result", 64'(mif.data_result), 64'hFFFFFFFD);
        do_op(1'b0, 1'b1, 32'd100, 32'd7, lat, bcnt);
        check("b2b second result", 64'(mif.data_result), 64'h0000000E);
        check("b2b second latency", 64'(lat), 64'd32);

        // MULT pulsed during RUN of 0x80000000 / -1 must be ignored.
        mif.ctrl_DIV      = 1'b1;
        mif.data_operandA = 32'h80000000;
        mif.data_operandB = 32'hFFFFFFFF;
        @(posedge clock); #1;
        mif.ctrl_DIV = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        mif.ctrl_MULT     = 1'b1;
        mif.data_operandA = 32'd3;
        mif.data_operandB = 32'd4;
        @(posedge clock); #1;
        mif.ctrl_MULT = 1'b0;
        rdy_pulses = 0;
        for (int k = 0; k < 45; k++) begin
            if (mif.data_resultRDY) begin
                rdy_pulses++;
                check("ignore result", 64'(mif.data_result), 64'h80000000);
                check("ignore exc", 64'(mif.data_exception), 64'd1);
            end
            @(posedge clock); #1;
        end
        check("ignore rdy pulses", 64'(rdy_pulses), 64'd1);

        // Reset in the middle of a multiply, with a start presented at the reset edge.
        mif.ctrl_MULT     = 1'b1;
        mif.data_operandA = 32'h00012345;
        mif.data_operandB = 32'h00006789;
        @(posedge clock); #1;
        mif.ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        ctrl_reset_n  = 1'b0;
        mif.ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        check("midrst result", 64'(mif.data_result), 64'd0);
        check("midrst exc",    64'(mif.data_exception), 64'd0);
        check("midrst rdy",    64'(mif.data_resultRDY), 64'd0);
        check("midrst busy",   64'(mif.busy), 64'd0);
        ctrl_reset_n  = 1'b1;
        mif.ctrl_MULT = 1'b0;
        @(posedge clock); #1;
        check("dropped start busy", 64'(mif.busy), 64'd0);
        do_op(1'b1, 1'b0, 32'd3, 32'd4, lat, bcnt);
        check("post-reset result",  64'(mif.data_result), 64'd12);
        check("post-reset exc",     64'(mif.data_exception), 64'd0);
        check("post-reset latency", 64'(lat), 64'd32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
